// File: rtl/srec_pkg.sv
// Shared definitions for the S-record emitter: ASCII constants, FSM encoding,
// record kinds and the nibble-to-ASCII helper.
package srec_pkg;

  localparam logic [7:0] CHAR_S  = 8'h53;
  localparam logic [7:0] CHAR_0  = 8'h30;
  localparam logic [7:0] CHAR_3  = 8'h33;
  localparam logic [7:0] CHAR_7  = 8'h37;
  localparam logic [7:0] CHAR_A  = 8'h41;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [4:0] {
    ST_IDLE,
    ST_S,
    ST_TYPE,
    ST_COUNT_HI,
    ST_COUNT_LO,
    ST_ADDR,
    ST_FETCH,
    ST_WAIT,
    ST_DATA_HI,
    ST_DATA_LO,
    ST_SUM_HI,
    ST_SUM_LO,
    ST_CR,
    ST_LF,
    ST_FINISH
  } state_t;

  typedef enum logic [1:0] {
    REC_HDR,
    REC_DATA,
    REC_TERM
  } rec_kind_t;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble);
    logic [7:0] ascii;
    if (nibble < 4'd10) ascii = CHAR_0 + {4'h0, nibble};
    else ascii = CHAR_A + {4'h0, nibble} - 8'd10;
    return ascii;
  endfunction

endpackage

// File: rtl/srec_hex_char.sv
// Combinational converter from one hex nibble to its uppercase ASCII digit.
module srec_hex_char
  import srec_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  assign ascii = nibble_to_ascii(nibble);

endmodule

// File: rtl/srec_emitter.sv
// Memory-dump engine emitting Motorola S3/S7 records as ASCII characters.
// Define SREC_HEADER_EN to prefix each dump with an S0 header record.
module srec_emitter
  import srec_pkg::*;
#(
  parameter int BYTES_PER_RECORD = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] start_address,
  input  logic [31:0] length,
  output logic        busy,
  output logic        done,
  output logic [31:0] read_address,
  output logic        read_enable,
  input  logic [7:0]  read_data,
  output logic [7:0]  char_data,
  output logic        char_valid,
  input  logic        char_ready
);

`ifdef SREC_HEADER_EN
  localparam logic HEADER_EN = 1'b1;
`else
  localparam logic HEADER_EN = 1'b0;
`endif

  state_t      state_reg, state_next;
  rec_kind_t   kind_reg;
  logic [31:0] start_addr_reg;
  logic [31:0] addr_reg;
  logic [31:0] remaining_reg;
  logic [31:0] rec_addr_reg;
  logic [7:0]  count_reg;
  logic [7:0]  rec_left_reg;
  logic [7:0]  sum_reg;
  logic [7:0]  byte_reg;
  logic [2:0]  nib_idx_reg;
  logic        hdr_pending_reg;

  logic        accept;
  logic [7:0]  rec_n;
  logic [7:0]  addr_byte;
  logic [3:0]  nibble_sel;
  logic [7:0]  hex_ascii;

  assign accept    = char_valid && char_ready;
  assign rec_n     = (remaining_reg < 32'(BYTES_PER_RECORD)) ? remaining_reg[7:0]
                                                              : 8'(BYTES_PER_RECORD);
  assign addr_byte = rec_addr_reg[{nib_idx_reg[2:1], 3'b000} +: 8];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (start) state_next = ST_S;
      ST_S:        if (accept) state_next = ST_TYPE;
      ST_TYPE:     if (accept) state_next = ST_COUNT_HI;
      ST_COUNT_HI: if (accept) state_next = ST_COUNT_LO;
      ST_COUNT_LO: if (accept) state_next = ST_ADDR;
      ST_ADDR: begin
        if (accept && nib_idx_reg == 3'd0)
          state_next = (kind_reg == REC_DATA) ? ST_FETCH : ST_SUM_HI;
      end
      ST_FETCH:    state_next = ST_WAIT;
      ST_WAIT:     state_next = ST_DATA_HI;
      ST_DATA_HI:  if (accept) state_next = ST_DATA_LO;
      ST_DATA_LO:  if (accept) state_next = (rec_left_reg == 8'd1) ? ST_SUM_HI : ST_FETCH;
      ST_SUM_HI:   if (accept) state_next = ST_SUM_LO;
      ST_SUM_LO:   if (accept) state_next = ST_CR;
      ST_CR:       if (accept) state_next = ST_LF;
      ST_LF:       if (accept) state_next = (kind_reg == REC_TERM) ? ST_FINISH : ST_S;
      ST_FINISH:   state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Record parameters are fixed when the leading 'S' is accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      kind_reg        <= REC_HDR;
      start_addr_reg  <= 32'd0;
      addr_reg        <= 32'd0;
      remaining_reg   <= 32'd0;
      rec_addr_reg    <= 32'd0;
      count_reg       <= 8'd0;
      rec_left_reg    <= 8'd0;
      sum_reg         <= 8'd0;
      byte_reg        <= 8'd0;
      nib_idx_reg     <= 3'd0;
      hdr_pending_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            start_addr_reg  <= start_address;
            addr_reg        <= start_address;
            remaining_reg   <= length;
            hdr_pending_reg <= HEADER_EN;
          end
        end
        ST_S: begin
          if (accept) begin
            sum_reg <= 8'd0;
            if (hdr_pending_reg) begin
              kind_reg        <= REC_HDR;
              rec_addr_reg    <= 32'd0;
              count_reg       <= 8'd3;
              hdr_pending_reg <= 1'b0;
            end else if (remaining_reg == 32'd0) begin
              kind_reg     <= REC_TERM;
              rec_addr_reg <= start_addr_reg;
              count_reg    <= 8'd5;
            end else begin
              kind_reg     <= REC_DATA;
              rec_addr_reg <= addr_reg;
              count_reg    <= rec_n + 8'd5;
              rec_left_reg <= rec_n;
            end
          end
        end
        ST_COUNT_LO: begin
          if (accept) begin
            sum_reg     <= sum_reg + count_reg;
            nib_idx_reg <= (kind_reg == REC_HDR) ? 3'd3 : 3'd7;
          end
        end
        ST_ADDR: begin
          if (accept) begin
            // A byte is complete once its low (even-index) nibble goes out.
            if (!nib_idx_reg[0]) sum_reg <= sum_reg + addr_byte;
            nib_idx_reg <= nib_idx_reg - 3'd1;
          end
        end
        ST_WAIT: begin
          byte_reg <= read_data;
          sum_reg  <= sum_reg + read_data;
        end
        ST_DATA_LO: begin
          if (accept) begin
            addr_reg      <= addr_reg + 32'd1;
            remaining_reg <= remaining_reg - 32'd1;
            rec_left_reg  <= rec_left_reg - 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nibble_sel = 4'h0;
    case (state_reg)
      ST_COUNT_HI: nibble_sel = count_reg[7:4];
      ST_COUNT_LO: nibble_sel = count_reg[3:0];
      ST_ADDR:     nibble_sel = rec_addr_reg[{nib_idx_reg, 2'b00} +: 4];
      ST_DATA_HI:  nibble_sel = byte_reg[7:4];
      ST_DATA_LO:  nibble_sel = byte_reg[3:0];
      ST_SUM_HI:   nibble_sel = ~sum_reg[7:4];
      ST_SUM_LO:   nibble_sel = ~sum_reg[3:0];
      default:     nibble_sel = 4'h0;
    endcase
  end

  srec_hex_char u_hex_char (
    .nibble (nibble_sel),
    .ascii  (hex_ascii)
  );

  always_comb begin
    char_data  = 8'h00;
    char_valid = 1'b1;
    case (state_reg)
      ST_S:    char_data = CHAR_S;
      ST_TYPE: begin
        case (kind_reg)
          REC_HDR:  char_data = CHAR_0;
          REC_DATA: char_data = CHAR_3;
          default:  char_data = CHAR_7;
        endcase
      end
      ST_COUNT_HI, ST_COUNT_LO, ST_ADDR, ST_DATA_HI, ST_DATA_LO,
      ST_SUM_HI, ST_SUM_LO: char_data = hex_ascii;
      ST_CR:   char_data = CHAR_CR;
      ST_LF:   char_data = CHAR_LF;
      default: char_valid = 1'b0;
    endcase
  end

  assign busy         = (state_reg != ST_IDLE) && (state_reg != ST_FINISH);
  assign done         = (state_reg == ST_FINISH);
  assign read_enable  = (state_reg == ST_FETCH);
  assign read_address = addr_reg;

endmodule

// File: doc/srec_emitter.md
Name: srec_emitter

Overview:
Memory-dump engine that produces Motorola S-record text for a UART transmitter. On a start pulse it reads a byte range through a synchronous read port and emits it as uppercase-hex S3 data records, each terminated with CR LF, followed by one S7 termination record. Sits between on-chip memory and the UART transmitter's character input.

Parameters:
BYTES_PER_RECORD, 16, maximum data bytes per S3 record (legal range 1..250)

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse that begins a dump; ignored while busy
start_address  input  32  first byte address, sampled when start is accepted
length  input  32  byte count, sampled when start is accepted; 0 is legal
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse after the S7 LF is accepted
read_address  output  32  memory byte address
read_enable  output  1  one-cycle read strobe
read_data  input  8  memory data, valid exactly one cycle after read_enable
char_data  output  8  ASCII character to the transmitter
char_valid  output  1  char_data is valid
char_ready  input  1  transmitter accepts the character when char_valid && char_ready

Behaviour:
- Clock is clock. Reset is reset_n, asynchronous and active-low. Reset values: busy=0, done=0, read_enable=0, char_valid=0, char_data=0, read_address=0, FSM in IDLE.
- Reset mid-dump aborts immediately; no partial record is completed.
- Handshake: once char_valid rises, char_data and char_valid hold stable until accepted. The next character may be presented in the cycle after acceptance.
- FSM states: IDLE, S, TYPE, COUNT_HI, COUNT_LO, ADDR (3-bit nibble index, 7 down to 0), FETCH, WAIT, DATA_HI, DATA_LO, SUM_HI, SUM_LO, CR, LF, FINISH.
- IDLE -> S on start: latch address and remaining count, set busy.
- Record body: 'S', then type '3' (data record) or '7' (termination). Then count = n+5 as 2 hex digits, where n = min(remaining, BYTES_PER_RECORD). Then the address as 8 hex digits, MSB first.
- Data bytes: for each byte, FETCH asserts read_enable for one cycle with read_address = current address. WAIT captures read_data. DATA_HI and DATA_LO emit the byte's two hex digits. Then increment the address and decrement remaining.
- After the last byte of the record: SUM_HI, SUM_LO, CR (0x0D), LF (0x0A).
- After LF: if remaining > 0, start the next S3 record; otherwise emit the S7 record (count 05, address = latched start_address, no data).
- After the S7 LF is accepted: FINISH pulses done for one cycle, busy drops in that same cycle, and the FSM returns to IDLE.
- If length = 0, only the S7 record is emitted.
- Checksum: 8-bit running sum of the count byte, the four address bytes and all data bytes, cleared at each record's 'S'. Emitted value is the ones' complement of the sum.
- Hex encoding: nibble 0-9 maps to 0x30+n; nibble A-F maps to 0x41+(n-10).
- Address arithmetic is 32-bit modulo 2^32 (0xFFFFFFFF+1 = 0x00000000). A record never splits on wrap; the record address is the address of its first byte.

Optional Feature:
SREC_HEADER_EN:
- Defined: before the first data record, emit the S0 header record "S0030000FC" CR LF. It uses a 4-nibble address of 0000, no data, and checksum FC.
- Undefined: no header is emitted; the stream starts directly with S3 (or S7 when length = 0).

Decomposition:
- Package srec_pkg holds:
  - ASCII constants CHAR_S, CHAR_0, CHAR_3, CHAR_7, CHAR_A, CHAR_CR, CHAR_LF;
  - the FSM state encoding (5-bit);
  - a nibble_to_ascii function.
- One natural sub-module, srec_hex_char: combinational 4-bit to ASCII converter, instantiated once on the nibble-select mux output.
- The checksum accumulator and counters stay in srec_emitter.

Test Plan:
- start_address=0x00001000, length=4, memory 01 02 03 04, char_ready=1 -> stream "S3090000100001020304DC\r\n" then "S70500001000EA\r\n", then one done pulse.
- length=0, start_address=0 -> only "S70500000000FA\r\n"; read_enable never asserted.
- length=17, BYTES_PER_RECORD=16, start_address=0x100 -> first record has count 15 at address 00000100; second record has count 06 at address 00000110; then the S7 record.
- Random char_ready low periods with the 4-byte case -> char_data stable whenever char_valid && !char_ready; character sequence identical to the first test.
- start_address=0xFFFFFFFF, length=2 -> read_address goes FFFFFFFF then 00000000; one S3 record at address FFFFFFFF.
- reset_n asserted mid-data -> char_valid, busy and read_enable are 0 immediately. A new start then produces a clean stream beginning with 'S'. A start pulsed while busy is ignored.
